// File: rtl/usr_pkg.sv
// Shared mode encodings for the universal shift register.
package usr_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

endpackage

// File: rtl/dff_arst.sv
// Single storage bit with asynchronous active-high reset to RV and a complementary output.
module dff_arst #(
  parameter logic RV = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic Q,
  output logic Qn
);

  // Capture D on the rising edge; reset takes effect immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) Q <= RV;
    else     Q <= D;
  end

  assign Qn = ~Q;

endmodule

// File: rtl/universal_shift_register.sv
// N-bit register with per-cycle mode select built from dff_arst cells.
// The top level only forms the next-state value and the zero flag.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int              WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SI_LSB,
  input  logic             SI_MSB,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic             SO_MSB,
  output logic             SO_LSB,
  output logic             ZERO
);

  if (WIDTH < 2) begin : g_bad_width
    $error("universal_shift_register: WIDTH must be at least 2");
  end

  logic [WIDTH-1:0] nxt;

  // Next-state selection; EN low or HOLD keeps the current value.
  always_comb begin
    nxt = Q;
    if (EN) begin
      case (MODE)
        MODE_HOLD: nxt = Q;
        MODE_LOAD: nxt = D;
        MODE_SHL:  nxt = {Q[WIDTH-2:0], SI_LSB};
        MODE_SHR:  nxt = {SI_MSB, Q[WIDTH-1:1]};
        MODE_ROL:  nxt = {Q[WIDTH-2:0], Q[WIDTH-1]};
        MODE_ROR:  nxt = {Q[0], Q[WIDTH-1:1]};
        MODE_ASR:  nxt = {Q[WIDTH-1], Q[WIDTH-1:1]};
        MODE_CLR:  nxt = '0;
        default:   nxt = Q;
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_arst #(.RV(RESET_VALUE[i])) u_bit (
      .CLK (CLK),
      .RST (RST),
      .D   (nxt[i]),
      .Q   (Q[i]),
      .Qn  (Qn[i])
    );
  end

  assign SO_MSB = Q[WIDTH-1];
  assign SO_LSB = Q[0];
  assign ZERO   = ~|Q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Randomised bench for universal_shift_register with an arithmetic reference model.
module tb_universal_shift_register;

  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [7:0] d = 8'd0;
  logic       si_lsb = 1'b0;
  logic       si_msb = 1'b0;
  logic [7:0] q, qn;
  logic       so_msb, so_lsb, zero;

  logic [7:0] exp_q = 8'd0;
  logic       chk_en = 1'b0;
  int         vectors = 0;
  int         miscompares = 0;

  universal_shift_register #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .D(d),
    .SI_LSB(si_lsb), .SI_MSB(si_msb),
    .Q(q), .Qn(qn), .SO_MSB(so_msb), .SO_LSB(so_lsb), .ZERO(zero)
  );

  always #5 clk = ~clk;

  // Reference: next register value from plain shift/or arithmetic.
  function automatic logic [7:0] model(input logic [7:0] cur, input logic e,
                                       input logic [2:0] m, input logic [7:0] dv,
                                       input logic sl, input logic sm);
    if (!e) return cur;
    case (m)
      3'd0: return cur;
      3'd1: return dv;
      3'd2: return (cur << 1) | {7'd0, sl};
      3'd3: return (cur >> 1) | {sm, 7'd0};
      3'd4: return (cur << 1) | (cur >> 7);
      3'd5: return (cur >> 1) | (cur << 7);
      3'd6: return (cur >> 1) | (cur & 8'h80);
      default: return 8'd0;
    endcase
  endfunction

  // Compare every observable output against the model away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (q !== exp_q) begin
        miscompares++;
        $display("FAIL cyc_q: got %h want %h", q, exp_q);
      end
      if (qn !== ~exp_q) begin
        miscompares++;
        $display("FAIL cyc_qn: got %h want %h", qn, ~exp_q);
      end
      if (so_msb !== exp_q[7] || so_lsb !== exp_q[0]) begin
        miscompares++;
        $display("FAIL cyc_so: got msb=%b lsb=%b want msb=%b lsb=%b",
                 so_msb, so_lsb, exp_q[7], exp_q[0]);
      end
      if (zero !== (exp_q == 8'd0)) begin
        miscompares++;
        $display("FAIL cyc_zero: got %b want %b", zero, (exp_q == 8'd0));
      end
    end
  end

  task automatic lit(input string nm, input logic [7:0] got, input logic [7:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic step(input logic e, input logic [2:0] m, input logic [7:0] dv,
                      input logic sl, input logic sm);
    logic [7:0] nx;
    @(negedge clk);
    en = e; mode = m; d = dv; si_lsb = sl; si_msb = sm;
    nx = model(exp_q, e, m, dv, sl, sm);
    @(posedge clk);
    #1;
    exp_q = nx;
  endtask

  // Reset pulse placed strictly between rising edges.
  task automatic async_reset();
    @(negedge clk);
    #2;
    en = 1'b0;
    rst = 1'b1;
    exp_q = RV;
    #1;
    lit("rst_q", q, 8'hA5);
    lit("rst_qn", qn, 8'h5A);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] seq [8];
    seq[0] = 8'h03; seq[1] = 8'h06; seq[2] = 8'h0C; seq[3] = 8'h18;
    seq[4] = 8'h30; seq[5] = 8'h60; seq[6] = 8'hC0; seq[7] = 8'h81;

    repeat (2) @(posedge clk);
    async_reset();
    chk_en = 1'b1;

    // 1: reset then load
    step(1, 3'd1, 8'h3C, 0, 0);
    lit("load_q", q, 8'h3C);
    lit("load_qn", qn, 8'hC3);

    // 2: shift left/right with serial bits
    step(1, 3'd1, 8'h81, 0, 0);
    lit("so_msb_before", {7'd0, so_msb}, 8'h01);
    step(1, 3'd2, 8'h00, 1, 0);
    lit("shl", q, 8'h03);
    step(1, 3'd3, 8'h00, 1, 0);
    lit("shr", q, 8'h01);

    // 3: rotate round trip
    step(1, 3'd1, 8'h81, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 3'd4, 8'($urandom), 1'($urandom), 1'($urandom));
      lit($sformatf("rol%0d", i), q, seq[i]);
    end
    step(1, 3'd5, 8'h00, 1, 1);
    lit("ror", q, 8'hC0);

    // 4: arithmetic shift and clear
    step(1, 3'd1, 8'h80, 0, 0);
    repeat (3) step(1, 3'd6, 8'h00, 0, 0);
    lit("asr_neg", q, 8'hF0);
    step(1, 3'd1, 8'h40, 0, 0);
    step(1, 3'd6, 8'h00, 1, 1);
    lit("asr_pos", q, 8'h20);
    step(1, 3'd7, 8'hFF, 1, 1);
    lit("clr_q", q, 8'h00);
    lit("clr_zero", {7'd0, zero}, 8'h01);

    // 5: enable low ignores every mode
    step(1, 3'd1, 8'h3C, 0, 0);
    for (int m = 0; m < 8; m++) step(0, 3'(m), 8'($urandom), 1, 1);
    lit("en_low", q, 8'h3C);

    // 6: reset coinciding with a load edge
    @(negedge clk);
    en = 1'b1; mode = 3'd1; d = 8'h77;
    @(posedge clk);
    rst = 1'b1;
    en = 1'b0;
    exp_q = RV;
    #1;
    lit("rst_on_edge", q, 8'hA5);
    @(negedge clk);
    rst = 1'b0;
    step(1, 3'd1, 8'hFF, 0, 0);
    lit("load_after_rst", q, 8'hFF);

    // Random traffic with occasional asynchronous resets.
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 39) == 0) async_reset();
      else step(($urandom_range(0, 3) != 0), 3'($urandom), 8'($urandom),
                1'($urandom), 1'($urandom));
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
